// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: FSM state encoding and default width.
package serial_arith_pkg;

  localparam int unsigned DefaultN = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StShift = SHIFT,
    StDone  = DONE
  } serial_state_e;

endpackage

// File: rtl/serial_sub_control.sv
// Sequencer for the serial subtractor: start/done handshake FSM plus the bit counter.
module serial_sub_control
  import serial_arith_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic clock,
  input  logic resetn,
  input  logic start,
  output logic load,
  output logic shift_en,
  output logic last_bit,
  output logic busy,
  output logic done
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  serial_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift_en = 1'b0;
    last_bit = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        shift_en = 1'b1;
        busy     = 1'b1;
        if (cnt_q == LastCnt) begin
          last_bit = 1'b1;
          cnt_d    = '0;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        done = 1'b1;
        // Held start keeps us here so a level request cannot retrigger.
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first: operand shift registers, result shift register and borrow flop.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N:0]   diff,
  output logic         busy,
  output logic         done
);

  logic         load, shift_en, last_bit;
  logic [N-1:0] op_a_q, op_b_q;
  logic [N:0]   res_q;
  logic         borrow_q;
  logic         bit_a, bit_b, bit_d, bit_bout;
  logic [N-1:0] res_shifted;

  serial_sub_control #(
    .N(N)
  ) u_control (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .load     (load),
    .shift_en (shift_en),
    .last_bit (last_bit),
    .busy     (busy),
    .done     (done)
  );

  always_comb begin
    bit_a    = op_a_q[0];
    bit_b    = op_b_q[0];
    bit_d    = bit_a ^ bit_b ^ borrow_q;
    bit_bout = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
    res_shifted        = res_q[N-1:0] >> 1;
    res_shifted[N-1]   = bit_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
    end else if (load) begin
      op_a_q   <= A;
      op_b_q   <= B;
      res_q    <= '0;
      borrow_q <= 1'b0;
    end else if (shift_en) begin
      op_a_q       <= op_a_q >> 1;
      op_b_q       <= op_b_q >> 1;
      res_q[N-1:0] <= res_shifted;
      borrow_q     <= bit_bout;
      if (last_bit) res_q[N] <= bit_bout;
    end
  end

  assign diff = res_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clock;
  logic         resetn;
  logic         start;
  logic [N-1:0] A, B;
  logic [N:0]   diff;
  logic         busy, done;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(
    .N(N)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .A      (A),
    .B      (B),
    .diff   (diff),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Borrow lands in bit N of the (N+1)-bit two's-complement difference.
  function automatic logic [N:0] ref_diff(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] r;
    r = {1'b0, a} - {1'b0, b};
    return r;
  endfunction

  // Stimulus only: launch one operation and wait (bounded) for done.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold,
                        output int busy_cycles, output int lat);
    @(negedge clock);
    A = a;
    B = b;
    start = 1'b1;
    busy_cycles = 0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clock);
      if (!hold) start = 1'b0;
      lat++;
      if (busy) busy_cycles++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (diff !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_active: diff=%h busy=%b done=%b, expected 0/0/0", diff, busy, done);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (diff !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: diff=%h busy=%b done=%b, expected 0/0/0", diff, busy, done);
    end
  endtask

  task automatic test_basic();
    int bc, lat;
    run_op(8'd100, 8'd37, 1'b0, bc, lat);
    checks++;
    if (diff !== 9'h03F || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: diff=%h done=%b busy=%b, expected 03f/1/0", diff, done, busy);
    end
    checks++;
    if (bc != N || lat != N + 1) begin
      errors++;
      $display("FAIL basic_timing: busy_cycles=%0d latency=%0d, expected %0d/%0d",
               bc, lat, N, N + 1);
    end
  endtask

  task automatic test_borrow();
    int bc, lat;
    run_op(8'd37, 8'd100, 1'b0, bc, lat);
    checks++;
    if (diff !== 9'h1C1) begin
      errors++;
      $display("FAIL borrow_37_100: diff=%h, expected 1c1", diff);
    end
    run_op(8'd0, 8'd1, 1'b0, bc, lat);
    checks++;
    if (diff !== 9'h1FF) begin
      errors++;
      $display("FAIL borrow_0_1: diff=%h, expected 1ff", diff);
    end
  endtask

  task automatic test_edges();
    int bc, lat;
    run_op(8'hFF, 8'hFF, 1'b0, bc, lat);
    checks++;
    if (diff !== 9'h000) begin
      errors++;
      $display("FAIL edge_ff_ff: diff=%h, expected 000", diff);
    end
    run_op(8'hFF, 8'h00, 1'b0, bc, lat);
    checks++;
    if (diff !== 9'h0FF) begin
      errors++;
      $display("FAIL edge_ff_00: diff=%h, expected 0ff", diff);
    end
    run_op(8'h00, 8'h00, 1'b0, bc, lat);
    checks++;
    if (diff !== 9'h000) begin
      errors++;
      $display("FAIL edge_00_00: diff=%h, expected 000", diff);
    end
  endtask

  task automatic test_random();
    int bc, lat;
    logic [N-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = N'($urandom_range(0, (1 << N) - 1));
      b = N'($urandom_range(0, (1 << N) - 1));
      run_op(a, b, 1'b0, bc, lat);
      checks++;
      if (diff !== ref_diff(a, b) || lat != N + 1 || bc != N) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h diff=%h lat=%0d busy=%0d, expected %h/%0d/%0d",
                 i, a, b, diff, lat, bc, ref_diff(a, b), N + 1, N);
      end
    end
  endtask

  task automatic test_hold_start();
    int bc, lat;
    int bad;
    logic [N:0] held;
    run_op(8'd200, 8'd55, 1'b1, bc, lat);
    held = ref_diff(8'd200, 8'd55);
    bad = 0;
    A = 8'd1;
    B = 8'd2;
    repeat (6) begin
      @(negedge clock);
      if (done !== 1'b1 || busy !== 1'b0 || diff !== held) bad++;
    end
    checks++;
    if (bad != 0 || lat != N + 1) begin
      errors++;
      $display("FAIL hold_no_restart: bad_samples=%0d lat=%0d diff=%h, expected 0/%0d/%h",
               bad, lat, diff, N + 1, held);
    end
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== held) begin
      errors++;
      $display("FAIL hold_release: done=%b busy=%b diff=%h, expected 0/0/%h",
               done, busy, diff, held);
    end
    run_op(8'd12, 8'd34, 1'b0, bc, lat);
    checks++;
    if (diff !== ref_diff(8'd12, 8'd34)) begin
      errors++;
      $display("FAIL hold_restart: diff=%h, expected %h", diff, ref_diff(8'd12, 8'd34));
    end
  endtask

  task automatic test_change_during_shift();
    int lat;
    logic [N-1:0] a, b;
    a = 8'h5A;
    b = 8'hC3;
    @(negedge clock);
    A = a;
    B = b;
    start = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      start = (lat == 3);
      if (lat == 2) begin
        A = N'($urandom);
        B = N'($urandom);
      end
      if (done) break;
    end
    checks++;
    if (diff !== ref_diff(a, b) || lat != N + 1) begin
      errors++;
      $display("FAIL shift_ignore_inputs: diff=%h lat=%0d, expected %h/%0d",
               diff, lat, ref_diff(a, b), N + 1);
    end
  endtask

  task automatic test_reset_mid();
    int bc, lat;
    @(negedge clock);
    A = 8'h00;
    B = 8'hFF;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (diff !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: diff=%h busy=%b done=%b, expected 0/0/0", diff, busy, done);
    end
    @(negedge clock);
    resetn = 1'b1;
    run_op(8'd5, 8'd3, 1'b0, bc, lat);
    checks++;
    if (diff !== 9'h002 || lat != N + 1) begin
      errors++;
      $display("FAIL reset_mid_recover: diff=%h lat=%0d, expected 002/%0d", diff, lat, N + 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_edges();
    test_random();
    test_hold_start();
    test_change_during_shift();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
